// File: rtl/motor_pkg.sv
// Shared definitions for the autonomous drive path.
// Holds the 3-bit motor command codes, the H-bridge direction pair
// encodings, the bridge driver state type and small decode helpers.
// The driving-algorithm block uses the same command codes.
package motor_pkg;

    // Motor command codes. Codes 3'b101..3'b111 are illegal and mean STOP.
    localparam logic [2:0] AUTO_STOP     = 3'b000;
    localparam logic [2:0] AUTO_FORWARD  = 3'b001;
    localparam logic [2:0] AUTO_BACKWARD = 3'b010;
    localparam logic [2:0] AUTO_LEFT     = 3'b011;
    localparam logic [2:0] AUTO_RIGHT    = 3'b100;

    // Direction pin pairs {inA, inB} for one bridge.
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_COAST = 2'b00;

    typedef enum logic [1:0] {
        StIdle,
        StDead,
        StRamp,
        StRun
    } drv_state_e;

    // True for the four codes that actually move the vehicle.
    function automatic logic is_motion(input logic [2:0] cmd);
        return (cmd == AUTO_FORWARD) || (cmd == AUTO_BACKWARD) ||
               (cmd == AUTO_LEFT) || (cmd == AUTO_RIGHT);
    endfunction

    // Straight-line commands use the higher target duty.
    function automatic logic is_straight(input logic [2:0] cmd);
        return (cmd == AUTO_FORWARD) || (cmd == AUTO_BACKWARD);
    endfunction

    function automatic logic [1:0] left_dir(input logic [2:0] cmd);
        case (cmd)
            AUTO_FORWARD:  return DIR_FWD;
            AUTO_BACKWARD: return DIR_REV;
            AUTO_LEFT:     return DIR_REV;
            AUTO_RIGHT:    return DIR_FWD;
            default:       return DIR_COAST;
        endcase
    endfunction

    function automatic logic [1:0] right_dir(input logic [2:0] cmd);
        case (cmd)
            AUTO_FORWARD:  return DIR_FWD;
            AUTO_BACKWARD: return DIR_REV;
            AUTO_LEFT:     return DIR_FWD;
            AUTO_RIGHT:    return DIR_REV;
            default:       return DIR_COAST;
        endcase
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter plus duty compare, shared by both wheels so the
// left and right enables stay phase-aligned.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   enable_i     - next-cycle enable (bridge driving)
//   duty_i       - next-cycle duty value
//   wrap_o       - counter is at all-ones this cycle (wraps on next edge)
//   pwm_o        - registered enable: high while counter < duty
module pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                wrap_o,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;

    // The compare uses next-cycle counter and duty so the registered output
    // equals (cnt_q < duty_q) with no extra cycle of lag.
    always_comb begin
        cnt_d = cnt_q + PWM_BITS'(1);
        pwm_d = enable_i && (cnt_d < duty_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign wrap_o = &cnt_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/motor_bridge_driver.sv
// Dual H-bridge driver for the left and right wheels.
// Turns the 3-bit autonomous motor command into direction pins and PWM
// enables, inserting a dead-time on every direction change, soft-starting
// duty in steps at each PWM wrap and forcing illegal codes to coast.
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   auto_motor_state  - motor command (000 stop, 001 fwd, 010 back,
//                       011 left, 100 right, others stop)
//   in1, in2          - left bridge direction (10 fwd, 01 rev, 00 coast)
//   in3, in4          - right bridge direction, same coding
//   ena, enb          - left/right PWM enables
//   busy              - high while in dead-time or ramping
// All outputs come straight from flops.
module motor_bridge_driver
    import motor_pkg::*;
#(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned DEAD_CYCLES   = 50_000,
    parameter int unsigned RAMP_STEP     = 16,
    parameter int unsigned DUTY_STRAIGHT = 230,
    parameter int unsigned DUTY_TURN     = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] auto_motor_state,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       in4,
    output logic       ena,
    output logic       enb,
    output logic       busy
);

    localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned SumW  = PWM_BITS + 1;

    localparam logic [DeadW-1:0]    DeadLast     = DeadW'(DEAD_CYCLES - 1);
    localparam logic [SumW-1:0]     RampStep     = SumW'(RAMP_STEP);
    localparam logic [PWM_BITS-1:0] DutyStraight = PWM_BITS'(DUTY_STRAIGHT);
    localparam logic [PWM_BITS-1:0] DutyTurn     = PWM_BITS'(DUTY_TURN);

    logic [2:0]          cmd_q;
    drv_state_e          state_q, state_d;
    logic [2:0]          act_q, act_d;     // command currently driven
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [DeadW-1:0]    dead_cnt_q, dead_cnt_d;
    logic [3:0]          pins_q, pins_d;
    logic                busy_q, busy_d;

    logic [PWM_BITS-1:0] target;
    logic [SumW-1:0]     duty_sum;
    logic [PWM_BITS-1:0] duty_sat;
    logic                drive_d;
    logic                pwm_wrap;
    logic                pwm_en;

    always_comb begin
        target   = is_straight(act_q) ? DutyStraight : DutyTurn;
        // Widen by one bit so a step past the top of the range cannot wrap.
        duty_sum = {1'b0, duty_q} + RampStep;
        duty_sat = (duty_sum > {1'b0, target}) ? target : duty_sum[PWM_BITS-1:0];
    end

    // Next-state logic. STOP and illegal codes win from every state.
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        duty_d     = duty_q;
        dead_cnt_d = dead_cnt_q;

        if (!is_motion(cmd_q)) begin
            state_d    = StIdle;
            act_d      = AUTO_STOP;
            duty_d     = '0;
            dead_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Bridge is already coasting, so no dead-time is needed.
                    state_d = StRamp;
                    act_d   = cmd_q;
                    duty_d  = '0;
                end
                StDead: begin
                    // Command changes inside the window do not restart it;
                    // the target is only picked up at exit.
                    if (dead_cnt_q == DeadLast) begin
                        state_d    = StRamp;
                        act_d      = cmd_q;
                        duty_d     = '0;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + DeadW'(1);
                    end
                end
                StRamp, StRun: begin
                    if (cmd_q != act_q) begin
                        state_d    = StDead;
                        duty_d     = '0;
                        dead_cnt_d = '0;
                    end else if ((state_q == StRamp) && pwm_wrap) begin
                        duty_d = duty_sat;
                        if (duty_sat == target) begin
                            state_d = StRun;
                        end
                    end
                end
                default: begin
                    state_d    = StIdle;
                    act_d      = AUTO_STOP;
                    duty_d     = '0;
                    dead_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so the registered pins line
    // up with the state they belong to.
    always_comb begin
        drive_d = (state_d == StRamp) || (state_d == StRun);
        pins_d  = drive_d ? {left_dir(act_d), right_dir(act_d)} : 4'b0000;
        busy_d  = (state_d == StDead) || (state_d == StRamp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= AUTO_STOP;
            state_q    <= StIdle;
            act_q      <= AUTO_STOP;
            duty_q     <= '0;
            dead_cnt_q <= '0;
            pins_q     <= 4'b0000;
            busy_q     <= 1'b0;
        end else begin
            cmd_q      <= auto_motor_state;
            state_q    <= state_d;
            act_q      <= act_d;
            duty_q     <= duty_d;
            dead_cnt_q <= dead_cnt_d;
            pins_q     <= pins_d;
            busy_q     <= busy_d;
        end
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (drive_d),
        .duty_i   (duty_d),
        .wrap_o   (pwm_wrap),
        .pwm_o    (pwm_en)
    );

    assign {in1, in2, in3, in4} = pins_q;
    assign ena  = pwm_en;
    assign enb  = pwm_en;
    assign busy = busy_q;

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Scoreboard bench for motor_bridge_driver with small parameters.
// A behavioural model advances once per clock edge and queues the expected
// pin vector; a monitor pops and compares on every falling edge.
module tb_motor_bridge_driver;

    localparam int PB = 4;
    localparam int DC = 5;
    localparam int RS = 4;
    localparam int DS = 12;
    localparam int DT = 8;
    localparam int PERIOD = 1 << PB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] auto_motor_state;
    logic       in1, in2, in3, in4, ena, enb, busy;

    always #5 clk = ~clk;

    motor_bridge_driver #(
        .PWM_BITS      (PB),
        .DEAD_CYCLES   (DC),
        .RAMP_STEP     (RS),
        .DUTY_STRAIGHT (DS),
        .DUTY_TURN     (DT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .auto_motor_state (auto_motor_state),
        .in1              (in1),
        .in2              (in2),
        .in3              (in3),
        .in4              (in4),
        .ena              (ena),
        .enb              (enb),
        .busy             (busy)
    );

    typedef enum {MIdle, MDead, MRamp, MRun} mode_t;

    mode_t      m_mode;
    int         m_duty;
    int         m_phase;
    int         m_dead_left;
    logic [2:0] m_cmd;
    logic [2:0] m_active;

    logic [6:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [6:0] outs();
        return {in1, in2, in3, in4, ena, enb, busy};
    endfunction

    function automatic bit motion(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd4);
    endfunction

    function automatic int target_of(input logic [2:0] c);
        return (c == 3'd1 || c == 3'd2) ? DS : DT;
    endfunction

    // {in1,in2,in3,in4} from the wheel mapping table.
    function automatic logic [3:0] pins_of(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b1010;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [6:0] expected();
        bit         drive;
        bit         en;
        logic [3:0] p;
        drive = (m_mode == MRamp) || (m_mode == MRun);
        p     = drive ? pins_of(m_active) : 4'b0000;
        en    = drive && (m_phase < m_duty);
        return {p, en, en, (m_mode == MDead) || (m_mode == MRamp)};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b (in1..in4,ena,enb,busy)",
                     name, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        m_mode      = MIdle;
        m_duty      = 0;
        m_phase     = 0;
        m_dead_left = 0;
        m_cmd       = 3'd0;
        m_active    = 3'd0;
    endtask

    // One clock edge of the reference behaviour, using pre-edge values.
    task automatic advance();
        int         ph_old;
        logic [2:0] c_old;
        if (!rst_n) begin
            reset_model();
            return;
        end
        ph_old  = m_phase;
        c_old   = m_cmd;
        m_phase = (m_phase + 1) % PERIOD;
        m_cmd   = auto_motor_state;
        if (!motion(c_old)) begin
            m_mode = MIdle;
            m_duty = 0;
        end else begin
            case (m_mode)
                MIdle: begin
                    m_mode   = MRamp;
                    m_active = c_old;
                    m_duty   = 0;
                end
                MDead: begin
                    m_dead_left--;
                    if (m_dead_left == 0) begin
                        m_mode   = MRamp;
                        m_active = c_old;
                        m_duty   = 0;
                    end
                end
                default: begin
                    if (c_old != m_active) begin
                        m_mode      = MDead;
                        m_dead_left = DC;
                        m_duty      = 0;
                    end else if (m_mode == MRamp && ph_old == PERIOD - 1) begin
                        m_duty = (m_duty + RS > target_of(m_active)) ?
                                 target_of(m_active) : m_duty + RS;
                        if (m_duty == target_of(m_active)) m_mode = MRun;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic [2:0] c);
        @(negedge clk);
        auto_motor_state = c;
        @(posedge clk);
        advance();
        exp_q.push_back(expected());
    endtask

    task automatic hold(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) step(c);
    endtask

    task automatic monitor();
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outputs", outs(), e);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        auto_motor_state = 3'd0;
        reset_model();
        fork
            monitor();
        join_none

        // Reset state, then release away from the edge.
        hold(3'd0, 3);
        #1 rst_n = 1'b1;
        hold(3'd0, 3);

        // Start from idle, full ramp to run.
        hold(3'd1, 60);
        // Reversal with dead-time.
        hold(3'd2, 60);
        // Turn after dead-time; saturates at the turn duty.
        hold(3'd3, 45);

        // Illegal code during ramp, then direct start with no dead-time.
        hold(3'd0, 3);
        hold(3'd4, 20);
        hold(3'd7, 4);
        hold(3'd4, 45);

        // Several changes inside one dead window.
        hold(3'd1, 50);
        hold(3'd2, 2);
        hold(3'd3, 45);

        // Asynchronous reset mid-run: pins must drop before the next edge.
        @(posedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 7'b0000000);
        reset_model();
        hold(3'd1, 2);
        #1 rst_n = 1'b1;
        hold(3'd0, 2);
        hold(3'd2, 40);

        // Randomised command sequence.
        for (int k = 0; k < 30; k++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            hold(c, $urandom_range(1, 40));
        end

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_bridge_driver.md
# motor_bridge_driver

Consumes the 3-bit autonomous motor command produced by the driving-algorithm block and turns it into dual H-bridge controls (direction pins plus PWM enables) for the left and right wheels. It owns the electrical safety of the drive path. A dead-time interval is inserted on every direction change, duty is soft-started in steps, and illegal codes are forced to coast. It sits between the navigation logic and the board-level motor driver pins.

## Interface
- PWM_BITS, 8: width of PWM counter; period = 2^PWM_BITS cycles
- DEAD_CYCLES, 50_000: cycles with all bridge pins low between two different motion commands
- RAMP_STEP, 16: duty increment applied at each PWM period wrap
- DUTY_STRAIGHT, 230: target duty for FORWARD/BACKWARD
- DUTY_TURN, 160: target duty for LEFT/RIGHT
- clk, input, 1: single system clock
- rst_n, input, 1: reset, asynchronous, active-low
- auto_motor_state, input, 3: command: 000 STOP, 001 FORWARD, 010 BACKWARD, 011 LEFT, 100 RIGHT; 101–111 = STOP
- in1 / in2, output, 1 each: left bridge direction; forward = 10, reverse = 01, coast = 00
- in3 / in4, output, 1 each: right bridge direction, same coding
- ena / enb, output, 1 each: left/right PWM enable
- busy, output, 1: high in DEAD or RAMP

## Operation
- Input is registered once into cmd_q; all decisions use cmd_q.
- Wheel mapping:
  - FORWARD: both wheels forward
  - BACKWARD: both wheels reverse
  - LEFT: left reverse, right forward
  - RIGHT: left forward, right reverse
- States:
  - IDLE: all pins 0, duty = 0
  - DEAD: all pins 0, dead counter running
  - RAMP: direction pins driven, duty climbing
  - RUN: duty = target
- Transitions:
  - IDLE + motion cmd → RAMP directly. Bridge is already coasting, so no dead time is needed. Duty starts at 0.
  - RAMP/RUN + different motion cmd → DEAD. Duty is cleared to 0 and the dead counter is cleared.
  - Any state + STOP (incl. illegal) → IDLE. Takes effect on the next edge and overrides everything.
  - DEAD: counter runs 0..DEAD_CYCLES-1. At the terminal count → RAMP with the latest cmd_q as target. A motion cmd change during DEAD does not restart the counter; the target is only re-read at exit.
  - RAMP: at each PWM wrap (pwm_cnt = all ones), duty = min(duty + RAMP_STEP, target).
    - Sum is computed PWM_BITS+1 wide, then saturated.
    - Duty reaching target → RUN.
  - RUN + same cmd: hold.
  - RAMP/RUN + same-class cmd with different target is impossible; any different code is a direction change.
- PWM:
  - pwm_cnt free-runs and wraps from all-ones to 0, never reset except by rst_n.
  - ena = enb = (pwm_cnt < duty) in RAMP/RUN, else 0.
  - duty 0 gives 0% on-time; max duty is (2^PWM_BITS − 1)/2^PWM_BITS.
- Direction pins never switch from 10 to 01 (or reverse) without at least DEAD_CYCLES of 00 between them, except via IDLE. IDLE itself is 00 for ≥1 cycle.
- Reset:
  - All outputs are 0, state IDLE, duty 0, pwm_cnt 0, cmd_q = STOP.
  - Reset asserted mid-operation forces pins low immediately (asynchronously).

## Timing
- Latency: a cmd change presented before edge k is sampled at k. Pins reflect the new state (DEAD/IDLE zeros, or RAMP direction) after edge k+1.
- All outputs are registered; there is no combinational path from auto_motor_state to any pin.
- First ena pulse after entering RAMP occurs after the next PWM wrap; duty is 0 until then.
- busy rises with DEAD/RAMP entry and falls on the edge entering RUN or IDLE.

## Structure
- Shared package (motor_pkg): command localparams (AUTO_STOP … AUTO_RIGHT), direction-pair constants DIR_FWD = 2'b10, DIR_REV = 2'b01, DIR_COAST = 2'b00. Also used by the driving-algorithm block.
- One sub-module, pwm_gen: counter plus compare, parameterised by PWM_BITS. Shared by both wheels; a single counter keeps ena and enb phase-aligned.

## Test plan
Benches use PWM_BITS=4, DEAD_CYCLES=5, RAMP_STEP=4, DUTY_STRAIGHT=12, DUTY_TURN=8.
- Reset: rst_n low mid-RUN → all pins 0 within the same cycle. After release, IDLE and cmd_q = STOP.
- Start: cmd 001 from IDLE → in1..in4 = 1010 two edges later. Duty goes 4, 8, 12 at three successive wraps, then RUN and busy = 0. ena is high 12 of every 16 cycles.
- Reversal: RUN FORWARD, cmd 010 → pins 0000 for exactly 5 cycles, then 0101 and ramp from 0. There is never a direct 10↔01 transition.
- Turn: cmd 011 → pins 0110 after dead time. Duty saturates at 8 via 4, 8; ena = enb.
- Illegal/stop: cmd 111 during RAMP → IDLE next edge, all 0. Then cmd 100 → 1001 with no DEAD.
- Change during DEAD: 001→010→011 within the dead window → single 5-cycle dead period, exits to 0110.
